// File: rtl/button_event_detector_pkg.sv
// Shared state encoding and default timing for the front-panel button event detector.
// Control logic decodes dbg_state / held using these definitions.
package button_event_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_HELD = 2'd2
  } bed_state_e;

  localparam int unsigned DEF_HOLD_CYCLES   = 5000000;
  localparam int unsigned DEF_REPEAT_CYCLES = 1250000;
  localparam int unsigned DEF_CNT_WIDTH     = 24;
  localparam int unsigned DEF_PCNT_WIDTH    = 8;

  function automatic logic state_is_held(input bed_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/button_event_detector_sat_counter.sv
// Saturating event counter with synchronous clear; clear and increment in the same
// cycle leave the count at one so that event is not lost.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/button_event_detector.sv
// Turns a conditioned button level into registered single-cycle press / release /
// long-press / auto-repeat events, plus a saturating press counter.
module button_event_detector
  import button_event_detector_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int unsigned PCNT_WIDTH    = DEF_PCNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  ip,
  input  logic                  clr,
  output logic                  press,
  output logic                  release_pulse,
  output logic                  release_long,
  output logic                  long_press,
  output logic                  rpt,
  output logic                  held,
  output logic [PCNT_WIDTH-1:0] press_count,
  output bed_state_e            dbg_state
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);

  bed_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic                 ip_q, ip_d;
  logic                 armed_q, armed_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 release_long_q, release_long_d;
  logic                 long_press_q, long_press_d;
  logic                 rpt_q, rpt_d;
  logic                 rise;

  // armed_q masks the first post-reset cycle: a level already high at reset
  // release is a stuck button, not a fresh press.
  assign rise = ip & ~ip_q & armed_q;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    ip_d           = ip;
    armed_d        = 1'b1;
    press_d        = 1'b0;
    release_d      = 1'b0;
    release_long_d = 1'b0;
    long_press_d   = 1'b0;
    rpt_d          = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_DOWN;
            timer_d = '0;
            press_d = 1'b1;
          end
        end
        ST_DOWN: begin
          if (!ip) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            release_d = 1'b1;
          end else if (timer_q == HOLD_LAST) begin
            state_d      = ST_HELD;
            timer_d      = '0;
            long_press_d = 1'b1;
          end else begin
            timer_d = timer_q + CNT_WIDTH'(1);
          end
        end
        ST_HELD: begin
          if (!ip) begin
            state_d        = ST_IDLE;
            timer_d        = '0;
            release_d      = 1'b1;
            release_long_d = 1'b1;
          end else if (REPEAT_CYCLES != 0) begin
            if (timer_q == REP_LAST) begin
              timer_d = '0;
              rpt_d   = 1'b1;
            end else begin
              timer_d = timer_q + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      ip_q           <= 1'b0;
      armed_q        <= 1'b0;
      press_q        <= 1'b0;
      release_q      <= 1'b0;
      release_long_q <= 1'b0;
      long_press_q   <= 1'b0;
      rpt_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      ip_q           <= ip_d;
      armed_q        <= armed_d;
      press_q        <= press_d;
      release_q      <= release_d;
      release_long_q <= release_long_d;
      long_press_q   <= long_press_d;
      rpt_q          <= rpt_d;
    end
  end

  // Counting press_d keeps press_count in step with the press pulse itself.
  sat_counter #(
    .WIDTH(PCNT_WIDTH)
  ) u_press_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (press_d),
    .count(press_count)
  );

  assign press         = press_q;
  assign release_pulse = release_q;
  assign release_long  = release_long_q;
  assign long_press    = long_press_q;
  assign rpt           = rpt_q;
  assign held          = state_is_held(state_q);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Bench for button_event_detector: two instances (repeat on / repeat off) share stimulus;
// a hold-duration reference model feeds per-instance expected queues checked each cycle.
module tb_button_event_detector;

  localparam int unsigned HOLD = 8;
  localparam int unsigned REP  = 4;
  localparam int unsigned PW   = 3;
  localparam int unsigned W    = 8 + PW;
  localparam int          CMAX = (1 << PW) - 1;

  logic clk, rst, en, ip, clr;
  logic          press0, rel0, rell0, lp0, rpt0, held0;
  logic [PW-1:0] cnt0;
  logic [1:0]    st0;
  logic          press1, rel1, rell1, lp1, rpt1, held1;
  logic [PW-1:0] cnt1;
  logic [1:0]    st1;
  logic [W-1:0]  act_v[2];

  int n_tests = 0;
  int n_fail  = 0;

  // Vector layout: {press, release, release_long, long_press, rpt, held, state[1:0], count}
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  bit m_act[2];
  bit m_prev[2];
  int m_dur[2];
  int m_cnt[2];
  int m_rep[2];

  button_event_detector #(
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_WIDTH(24), .PCNT_WIDTH(PW)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .ip(ip), .clr(clr),
    .press(press0), .release_pulse(rel0), .release_long(rell0), .long_press(lp0),
    .rpt(rpt0), .held(held0), .press_count(cnt0), .dbg_state(st0)
  );

  button_event_detector #(
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(0), .CNT_WIDTH(24), .PCNT_WIDTH(PW)
  ) u_dut_norep (
    .clk(clk), .rst(rst), .en(en), .ip(ip), .clr(clr),
    .press(press1), .release_pulse(rel1), .release_long(rell1), .long_press(lp1),
    .rpt(rpt1), .held(held1), .press_count(cnt1), .dbg_state(st1)
  );

  assign act_v[0] = {press0, rel0, rell0, lp0, rpt0, held0, st0, cnt0};
  assign act_v[1] = {press1, rel1, rell1, lp1, rpt1, held1, st1, cnt1};

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks how many cycles the current press has lasted
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i]  = 1'b0;
      m_prev[i] = 1'b1;
      m_dur[i]  = 0;
      m_cnt[i]  = 0;
    end
  endtask

  function automatic logic [W-1:0] model_step(input int i, input bit ipv, input bit env,
                                               input bit clrv);
    bit pr, rl, rll, lpv, rp;
    logic [1:0] st;
    pr = 0; rl = 0; rll = 0; lpv = 0; rp = 0;
    if (!env) begin
      m_act[i] = 1'b0;
    end else if (!m_act[i]) begin
      if (ipv && !m_prev[i]) begin
        m_act[i] = 1'b1;
        m_dur[i] = 0;
        pr = 1;
      end
    end else if (!ipv) begin
      rl  = 1;
      rll = (m_dur[i] >= HOLD);
      m_act[i] = 1'b0;
    end else begin
      m_dur[i]++;
      if (m_dur[i] == HOLD) lpv = 1;
      else if (m_rep[i] != 0 && m_dur[i] > HOLD && ((m_dur[i] - HOLD) % m_rep[i]) == 0) rp = 1;
    end
    m_prev[i] = ipv;
    if (clrv) m_cnt[i] = pr ? 1 : 0;
    else if (pr && m_cnt[i] < CMAX) m_cnt[i]++;
    if (!m_act[i]) st = 2'd0;
    else if (m_dur[i] >= HOLD) st = 2'd2;
    else st = 2'd1;
    return {pr, rl, rll, lpv, rp, m_act[i], st, PW'(m_cnt[i])};
  endfunction

  // Driver: one call = one clock cycle of stimulus, entered and left at posedge+2
  task automatic step(input bit ipv, input bit env, input bit clrv);
    ip  = ipv;
    en  = env;
    clr = clrv;
    exp_q0.push_back(model_step(0, ipv, env, clrv));
    exp_q1.push_back(model_step(1, ipv, env, clrv));
    @(posedge clk);
    #2;
  endtask

  task automatic hold_level(input bit ipv, input int n);
    for (int k = 0; k < n; k++) step(ipv, 1'b1, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (act_v[i] !== '0) begin
        n_fail++;
        $display("FAIL %s inst%0d got=%b exp=%b", tag, i, act_v[i], {W{1'b0}});
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
  endtask

  // Monitor / scoreboard: compares outputs 1 time unit after each active edge
  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q0.pop_front();
      n_tests++;
      if (act_v[0] !== e) begin
        n_fail++;
        $display("FAIL outputs inst0 t=%0t got=%b exp=%b", $time, act_v[0], e);
      end
    end
    if (exp_q1.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q1.pop_front();
      n_tests++;
      if (act_v[1] !== e) begin
        n_fail++;
        $display("FAIL outputs inst1_norep t=%0t got=%b exp=%b", $time, act_v[1], e);
      end
    end
  end

  initial begin
    m_rep[0] = REP;
    m_rep[1] = 0;
    rst = 1'b0; en = 1'b0; ip = 1'b0; clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_zero("reset_state");
    @(posedge clk);
    #2;
    rst = 1'b1;

    // short press
    hold_level(1'b0, 2);
    hold_level(1'b1, 5);
    hold_level(1'b0, 3);
    // long press with repeat
    hold_level(1'b1, 20);
    hold_level(1'b0, 3);
    // release on the cycle the hold would have expired
    hold_level(1'b1, HOLD);
    hold_level(1'b0, 3);
    // saturation, then clear coincident with a press
    for (int k = 0; k < 9; k++) begin
      hold_level(1'b1, 1);
      hold_level(1'b0, 2);
    end
    step(1'b1, 1'b1, 1'b1);
    hold_level(1'b1, 2);
    hold_level(1'b0, 2);
    // enable dropped mid-HELD, restored while still pressed
    hold_level(1'b1, 12);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    hold_level(1'b1, 3);
    hold_level(1'b0, 2);
    hold_level(1'b1, 3);
    hold_level(1'b0, 2);
    // reset mid-DOWN with the button still pressed
    hold_level(1'b1, 3);
    do_reset();
    hold_level(1'b1, 4);
    hold_level(1'b0, 2);
    hold_level(1'b1, 2);
    hold_level(1'b0, 2);

    // randomized runs of levels, with occasional enable drops and clears
    for (int r = 0; r < 60; r++) begin
      bit lvl;
      int len;
      lvl = r[0];
      len = $urandom_range(1, 22);
      for (int k = 0; k < len; k++) begin
        step(lvl, ($urandom_range(0, 24) != 0), ($urandom_range(0, 30) == 0));
      end
      if (r == 37) do_reset();
    end
    hold_level(1'b0, 3);

    n_tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d/%0d exp=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
